// File: rtl/key_search_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_search_controller_pkg
// Purpose  : Shared rc4 package for the key search controller. Holds the
//            FSM state encoding, the bounds of a printable message character,
//            the default message depth and the character classifier.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package key_search_controller_pkg;

  localparam int MSG_DEP_DEFAULT = 32;

  // A decrypted byte is accepted if it is lower-case ASCII or a space
  localparam logic [7:0] CHAR_LO    = 8'h61;
  localparam logic [7:0] CHAR_HI    = 8'h7A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    LAUNCH_INIT = 4'd1,
    WAIT_INIT   = 4'd2,
    LAUNCH_KSA  = 4'd3,
    WAIT_KSA    = 4'd4,
    LAUNCH_DEC  = 4'd5,
    WAIT_DEC    = 4'd6,
    CHECK       = 4'd7,
    NEXT_KEY    = 4'd8,
    FOUND       = 4'd9,
    FAIL        = 4'd10
  } state_t;

  function automatic logic is_msg_char(input logic [7:0] b);
    return ((b >= CHAR_LO) && (b <= CHAR_HI)) || (b == CHAR_SPACE);
  endfunction

endpackage : key_search_controller_pkg
`default_nettype wire

// File: rtl/key_search_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : key_search_controller_if
// Purpose  : Bundle between the key search controller and the RC4 sub-blocks
//            (S-init, KSA, decrypt) plus the decrypted-message store.
// Ports    : secret_key  - candidate key (controller -> sub-blocks)
//            sub_rst     - return sub-blocks to idle (controller -> sub-blocks)
//            init_start/ksa_start/dec_start - launch pulses
//            init_done/ksa_done/dec_done    - level completion flags
//            msg_addr    - message store read address
//            msg_data    - read data, one cycle after msg_addr
//            Modport master = controller, slave = sub-blocks / store.
// Revision : 1.0 - initial release
// ============================================================================
interface key_search_controller_if
  import key_search_controller_pkg::*;
#(
  parameter int MSG_DEP = MSG_DEP_DEFAULT
);

  logic [23:0]                secret_key;
  logic                       sub_rst;
  logic                       init_start;
  logic                       ksa_start;
  logic                       dec_start;
  logic                       init_done;
  logic                       ksa_done;
  logic                       dec_done;
  logic [$clog2(MSG_DEP)-1:0] msg_addr;
  logic [7:0]                 msg_data;

  modport master (
    output secret_key, sub_rst, init_start, ksa_start, dec_start, msg_addr,
    input  init_done, ksa_done, dec_done, msg_data
  );

  modport slave (
    input  secret_key, sub_rst, init_start, ksa_start, dec_start, msg_addr,
    output init_done, ksa_done, dec_done, msg_data
  );

endinterface : key_search_controller_if
`default_nettype wire

// File: rtl/key_search_controller_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : edge_detect
// Purpose  : Rising-edge detector for a level done flag. rise is high in the
//            cycle where level is high and was low the cycle before, so a
//            done flag left high by a previous run never looks like a new
//            completion.
// Ports    : clk, reset (async, active-high), level (in), rise (out)
// Revision : 1.0 - initial release
// ============================================================================
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= 1'b0;
    end else begin
      prev <= level;
    end
  end

  assign rise = level & ~prev;

endmodule : edge_detect
`default_nettype wire

// File: rtl/key_search_controller.sv
`default_nettype none
// ============================================================================
// Module   : key_search_controller
// Purpose  : Brute-force RC4 key search sequencer. For each candidate key it
//            resets the sub-blocks, runs S-init, KSA and decrypt in turn, then
//            streams the decrypted message and accepts the key if every byte
//            is lower-case ASCII or space.
// Ports    : clk        - clock
//            reset      - asynchronous active-high reset
//            start      - begin a search from key 0 (ignored while busy)
//            sub        - master side of key_search_controller_if
//            busy       - search in progress
//            key_found  - valid key held on sub.secret_key
//            key_fail   - search space exhausted
// Revision : 1.0 - initial release
// ============================================================================
module key_search_controller
  import key_search_controller_pkg::*;
#(
  parameter int MSG_DEP  = MSG_DEP_DEFAULT,
  parameter int KEY_BITS = 22
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  key_search_controller_if.master sub,
  output logic                    busy,
  output logic                    key_found,
  output logic                    key_fail
);

  localparam int                  AW       = $clog2(MSG_DEP);
  localparam int                  CW       = AW + 1;
  localparam logic [CW-1:0]       CNT_LAST = CW'(MSG_DEP);
  localparam logic [KEY_BITS-1:0] KEY_MAX  = '1;

  state_t              state;
  state_t              state_nxt;
  logic [KEY_BITS-1:0] key;
  logic [CW-1:0]       chk_cnt;
  logic                key_clr;
  logic                key_inc;
  logic                sub_rst_req;
  logic                init_rise;
  logic                ksa_rise;
  logic                dec_rise;
  logic                byte_ok;

  edge_detect u_init_edge (.clk(clk), .reset(reset), .level(sub.init_done), .rise(init_rise));
  edge_detect u_ksa_edge  (.clk(clk), .reset(reset), .level(sub.ksa_done),  .rise(ksa_rise));
  edge_detect u_dec_edge  (.clk(clk), .reset(reset), .level(sub.dec_done),  .rise(dec_rise));

  // msg_data answers the address issued in the previous CHECK cycle
  assign byte_ok = is_msg_char(sub.msg_data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // chk_cnt = cycles spent in CHECK so far: address chk_cnt is issued and
  // byte chk_cnt-1 is tested in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key     <= '0;
      chk_cnt <= '0;
    end else begin
      if (key_clr) begin
        key <= '0;
      end else if (key_inc) begin
        key <= key + KEY_BITS'(1);
      end
      if (state == CHECK) begin
        chk_cnt <= chk_cnt + CW'(1);
      end else begin
        chk_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    key_clr     = 1'b0;
    key_inc     = 1'b0;
    sub_rst_req = 1'b0;
    case (state)
      IDLE, FOUND, FAIL: begin
        if (start) begin
          key_clr     = 1'b1;
          sub_rst_req = 1'b1;
          state_nxt   = LAUNCH_INIT;
        end
      end
      LAUNCH_INIT: state_nxt = WAIT_INIT;
      WAIT_INIT:   if (init_rise) state_nxt = LAUNCH_KSA;
      LAUNCH_KSA:  state_nxt = WAIT_KSA;
      WAIT_KSA:    if (ksa_rise) state_nxt = LAUNCH_DEC;
      LAUNCH_DEC:  state_nxt = WAIT_DEC;
      WAIT_DEC:    if (dec_rise) state_nxt = CHECK;
      CHECK: begin
        if ((chk_cnt != '0) && !byte_ok) begin
          state_nxt = NEXT_KEY;
        end else if (chk_cnt == CNT_LAST) begin
          state_nxt = FOUND;
        end
      end
      NEXT_KEY: begin
        if (key == KEY_MAX) begin
          state_nxt = FAIL;
        end else begin
          key_inc     = 1'b1;
          sub_rst_req = 1'b1;
          state_nxt   = LAUNCH_INIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // sub_rst is raised in the cycle before LAUNCH_INIT, so it can never
  // coincide with a launch pulse. The idle-state request follows start
  // directly, hence the reset gate keeps it low while reset is applied.
  assign sub.sub_rst    = sub_rst_req & ~reset;
  assign sub.init_start = (state == LAUNCH_INIT);
  assign sub.ksa_start  = (state == LAUNCH_KSA);
  assign sub.dec_start  = (state == LAUNCH_DEC);
  assign sub.secret_key = 24'(key);
  assign sub.msg_addr   = ((state == CHECK) && (chk_cnt < CNT_LAST)) ? chk_cnt[AW-1:0] : '0;

  assign busy      = (state != IDLE) && (state != FOUND) && (state != FAIL);
  assign key_found = (state == FOUND);
  assign key_fail  = (state == FAIL);

endmodule : key_search_controller
`default_nettype wire

// File: tb/tb_key_search_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_search_controller
// Purpose  : Self-checking bench for key_search_controller (KEY_BITS=3).
//            Sub-block models with fixed done latencies and a message store
//            whose contents depend on the candidate key. Expected candidate
//            outcomes and search results are queued by the stimulus and
//            compared by an independent monitor.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_search_controller;

  localparam int MSG_DEP  = 32;
  localparam int KEY_BITS = 3;
  localparam int INIT_LAT = 256;
  localparam int KSA_LAT  = 768;
  localparam int DEC_LAT  = 160;
  localparam int LIM      = 20000;

  typedef struct { int key; int len; } cand_t;
  typedef struct { int found; int fail; int key; int n_init; int n_sr; } res_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy, key_found, key_fail;

  key_search_controller_if #(.MSG_DEP(MSG_DEP)) bus ();

  key_search_controller #(.MSG_DEP(MSG_DEP), .KEY_BITS(KEY_BITS)) dut (
    .clk(clk), .reset(reset), .start(start), .sub(bus),
    .busy(busy), .key_found(key_found), .key_fail(key_fail)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  int    mode   = 0;
  logic  stale_init = 1'b0;
  cand_t cand_q[$];
  res_t  res_q[$];

  // CHECK cycles per candidate, hand-derived from the message tables below
  int len_m0[4] = '{2, 7, 33, 33};
  int len_m1[8] = '{2, 7, 33, 12, 6, 7, 8, 9};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mode 0: only key 3 decrypts to a clean message. Mode 1: no key does.
  function automatic logic [7:0] msg_byte(input int key, input int addr, input int m);
    logic [7:0] b;
    b = (addr % 27 == 26) ? 8'h20 : 8'(8'h61 + addr % 27);
    case (key)
      0: if (addr == 0)  b = 8'h41;
      1: if (addr == 5)  b = 8'h7B;
      2: if (addr == 31) b = 8'h60;
      3: if (m == 1 && addr == 10) b = 8'h21;
      default: if (addr == key) b = 8'h80;
    endcase
    return b;
  endfunction

  // ---------------- sub-block and message store models ----------------
  int icnt, ihold, kcnt, dcnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.init_done <= 1'b0; icnt <= 0; ihold <= 0;
    end else if (bus.sub_rst) begin
      icnt <= 0; ihold <= 0;
      if (!stale_init) bus.init_done <= 1'b0;
    end else if (bus.init_start) begin
      icnt  <= INIT_LAT - 1;
      ihold <= stale_init ? 40 : 0;
    end else begin
      if (ihold == 1) bus.init_done <= 1'b0;
      if (ihold > 0) ihold <= ihold - 1;
      if (icnt > 1) icnt <= icnt - 1;
      else if (icnt == 1) begin icnt <= 0; bus.init_done <= 1'b1; end
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.ksa_done <= 1'b0; kcnt <= 0;
    end else if (bus.sub_rst) begin
      bus.ksa_done <= 1'b0; kcnt <= 0;
    end else if (bus.ksa_start) kcnt <= KSA_LAT - 1;
    else if (kcnt > 1) kcnt <= kcnt - 1;
    else if (kcnt == 1) begin kcnt <= 0; bus.ksa_done <= 1'b1; end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.dec_done <= 1'b0; dcnt <= 0;
    end else if (bus.sub_rst) begin
      bus.dec_done <= 1'b0; dcnt <= 0;
    end else if (bus.dec_start) dcnt <= DEC_LAT - 1;
    else if (dcnt > 1) dcnt <= dcnt - 1;
    else if (dcnt == 1) begin dcnt <= 0; bus.dec_done <= 1'b1; end
  end

  always @(posedge clk) bus.msg_data <= msg_byte(int'(bus.secret_key), int'(bus.msg_addr), mode);

  // ---------------- monitor ----------------
  int   n_init, n_sr, init_t, t0, cand_key, len;
  logic armed, prev_dec, prev_found, prev_fail;
  cand_t c;
  res_t  r;

  always @(negedge clk) begin
    if (reset) begin
      n_init = 0; n_sr = 0; init_t = -1; armed = 0;
      prev_dec = 0; prev_found = 0; prev_fail = 0;
    end else begin
      if (bus.init_start) begin n_init++; init_t = cyc; end
      if (bus.ksa_start && init_t >= 0) check("init_to_ksa_gap", cyc - init_t, INIT_LAT + 1);
      if (bus.sub_rst) begin
        n_sr++;
        check("sub_rst_with_start", int'({bus.init_start, bus.ksa_start, bus.dec_start}), 0);
      end
      if (bus.dec_done && !prev_dec) begin
        armed = 1; t0 = cyc; cand_key = int'(bus.secret_key);
      end
      if (armed && (bus.sub_rst || key_found || key_fail)) begin
        armed = 0;
        len = cyc - t0 - (key_fail ? 2 : 1);
        if (cand_q.size() == 0) check("unexpected_candidate", cand_key, -1);
        else begin
          c = cand_q.pop_front();
          check("cand_key", cand_key, c.key);
          check("check_len", len, c.len);
        end
      end
      if ((key_found && !prev_found) || (key_fail && !prev_fail)) begin
        if (res_q.size() == 0) check("unexpected_result", int'(key_found), -1);
        else begin
          r = res_q.pop_front();
          check("res_found", int'(key_found), r.found);
          check("res_fail", int'(key_fail), r.fail);
          check("res_key", int'(bus.secret_key), r.key);
          check("res_busy", int'(busy), 0);
          check("res_init_pulses", n_init, r.n_init);
          check("res_sub_rst_pulses", n_sr, r.n_sr);
        end
        n_init = 0; n_sr = 0;
      end
      prev_dec = bus.dec_done; prev_found = key_found; prev_fail = key_fail;
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_cands(input int m, input int n);
    for (int k = 0; k < n; k++)
      cand_q.push_back('{key: k, len: (m == 0) ? len_m0[k] : len_m1[k]});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  function automatic logic cond_hit(input int which);
    case (which)
      0: return bus.dec_start && (bus.secret_key == 24'd0);
      1: return key_found || key_fail;
      2: return bus.ksa_start;
      default: return bus.ksa_start && (bus.secret_key == 24'd5);
    endcase
  endfunction

  task automatic wait_cond(input int which, input string name);
    int n;
    n = 0;
    while (!cond_hit(which) && n < LIM) begin @(posedge clk); #1; n++; end
    if (!cond_hit(which)) begin
      checks++; errors++;
      $display("FAIL timeout %s: waited %0d cycles", name, n);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_found"}, int'(key_found), 0);
    check({tag, "_fail"}, int'(key_fail), 0);
    check({tag, "_key"}, int'(bus.secret_key), 0);
    check({tag, "_sub_rst"}, int'(bus.sub_rst), 0);
    check({tag, "_starts"}, int'({bus.init_start, bus.ksa_start, bus.dec_start}), 0);
    check({tag, "_msg_addr"}, int'(bus.msg_addr), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_all_zero("reset");
    reset = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("idle_no_search", int'(busy), 0);

    // Search 1: key 3 is valid; start during WAIT_DEC must be ignored
    mode = 0;
    push_cands(0, 4);
    res_q.push_back('{found: 1, fail: 0, key: 3, n_init: 4, n_sr: 4});
    pulse_start();
    check("busy_after_start", int'(busy), 1);
    wait_cond(0, "dec_start_key0");
    repeat (10) @(posedge clk); #1;
    start = 1'b1; #1;
    check("busy_start_no_sub_rst", int'(bus.sub_rst), 0);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_start_ignored_key", int'(bus.secret_key), 0);
    check("busy_start_ignored_busy", int'(busy), 1);
    wait_cond(1, "search1_done");
    repeat (5) @(posedge clk); #1;
    check("found_hold", int'(key_found), 1);
    check("found_hold_key", int'(bus.secret_key), 3);

    // Search 2: restart from FOUND, nothing valid -> FAIL after key 7
    mode = 1;
    push_cands(1, 8);
    res_q.push_back('{found: 0, fail: 1, key: 7, n_init: 8, n_sr: 8});
    pulse_start();
    check("restart_found_cleared", int'(key_found), 0);
    check("restart_key0", int'(bus.secret_key), 0);
    wait_cond(1, "search2_done");
    repeat (5) @(posedge clk); #1;
    check("fail_hold", int'(key_fail), 1);
    check("fail_hold_key", int'(bus.secret_key), 7);

    // Search 3: init_done stale-high at launch; reset at key 5 in WAIT_KSA
    stale_init = 1'b1;
    push_cands(1, 5);
    pulse_start();
    wait_cond(2, "stale_ksa_start");
    stale_init = 1'b0;
    wait_cond(3, "ksa_start_key5");
    repeat (5) @(posedge clk); #1;
    check("pre_reset_busy", int'(busy), 1);
    reset = 1'b1; #1;
    check_all_zero("midrun_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("post_reset_idle", int'(busy), 0);

    // Search 4: from IDLE after reset, key 3 valid again
    mode = 0;
    push_cands(0, 4);
    res_q.push_back('{found: 1, fail: 0, key: 3, n_init: 4, n_sr: 4});
    pulse_start();
    check("post_reset_key0", int'(bus.secret_key), 0);
    wait_cond(1, "search4_done");
    repeat (5) @(posedge clk); #1;

    check("cand_q_drained", cand_q.size(), 0);
    check("res_q_drained", res_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_key_search_controller
`default_nettype wire

// File: doc/key_search_controller.md
KEY_SEARCH_CONTROLLER -- requirements
Module: key_search_controller

Interface
REQ-001 Parameter MSG_DEP, default 32: message length in bytes checked per key.
REQ-002 Parameter KEY_BITS, default 22: width of the searched key field; upper 24-KEY_BITS key bits are zero.
REQ-003 Port clk  input  1: single clock; all state changes on rising edge.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Port start  input  1: begin a search from key 0; sampled in IDLE, FOUND or FAIL only.
REQ-006 Port secret_key  output  24: candidate key driven to the S-init, KSA and decrypt sub-blocks.
REQ-007 Port sub_rst  output  1: one-cycle pulse returning all sub-blocks to their idle state before each new key.
REQ-008 Ports init_start, ksa_start, dec_start  output  1 each: one-cycle launch pulses.
REQ-009 Ports init_done, ksa_done, dec_done  input  1 each: level completion flags from the sub-blocks.
REQ-010 Port msg_addr  output  $clog2(MSG_DEP): read address into the decrypted-message store.
REQ-011 Port msg_data  input  8: decrypted byte; valid exactly one cycle after msg_addr is presented.
REQ-012 Ports busy, key_found, key_fail  output  1 each: search running; valid key held on secret_key; search space exhausted.

Function
REQ-013 The FSM SHALL have states IDLE, LAUNCH_INIT, WAIT_INIT, LAUNCH_KSA, WAIT_KSA, LAUNCH_DEC, WAIT_DEC, CHECK, NEXT_KEY, FOUND, FAIL.
REQ-014 IDLE/FOUND/FAIL + start: key counter <= 0, key_found/key_fail <= 0, pulse sub_rst, go to LAUNCH_INIT.
REQ-015 Each LAUNCH_x state SHALL assert its x_start for exactly one cycle and move to WAIT_x.
REQ-016 WAIT_x SHALL advance only on a rising edge of x_done (current high, previous cycle low), so a stale held done never completes a phase.
REQ-017 Phase order: WAIT_INIT -> LAUNCH_KSA -> WAIT_KSA -> LAUNCH_DEC -> WAIT_DEC -> CHECK.
REQ-018 CHECK SHALL issue msg_addr 0..MSG_DEP-1 on consecutive cycles and test each returned byte one cycle later (pipelined, one byte/cycle).
REQ-019 A byte is valid iff 8'h61..8'h7A or 8'h20; first invalid byte SHALL end CHECK immediately (remaining addresses unused) and go to NEXT_KEY.
REQ-020 All MSG_DEP bytes valid -> FOUND; CHECK latency for a passing key = MSG_DEP+1 cycles.
REQ-021 NEXT_KEY: if key == 2^KEY_BITS-1 -> FAIL with no increment; else key <= key+1, pulse sub_rst, go to LAUNCH_INIT.
REQ-022 secret_key = {zeros, key counter}; changes only in NEXT_KEY or on start, stable through all phases of a candidate.
REQ-023 busy = 1 in every state except IDLE, FOUND, FAIL.
REQ-024 FOUND holds key_found=1 and secret_key; FAIL holds key_fail=1; both persist until start or reset.
REQ-025 start while busy SHALL be ignored.
REQ-026 sub_rst and x_start SHALL never be asserted in the same cycle.

Reset
REQ-027 reset SHALL force IDLE immediately, including mid-search; key counter=0, secret_key=0, all start pulses, sub_rst, busy, key_found, key_fail=0, msg_addr=0, done-edge history=0.
REQ-028 After reset deassertion no search SHALL begin without a new start.

Structure
REQ-029 State enum, valid-character bounds (8'h61, 8'h7A, 8'h20) and MSG_DEP default SHALL live in the shared rc4 package.
REQ-030 The done-rising-edge detector SHALL be one sub-module, edge_detect, instantiated once per done input.

Verification
REQ-031 Bench models with done latencies init 256, ksa 768, dec 160 cycles; message valid for key 3 only -> key_found=1, secret_key=24'h000003, busy=0.
REQ-032 Candidate whose byte 0 = 8'h41 -> CHECK exits after 2 cycles, secret_key increments by 1, one sub_rst pulse observed.
REQ-033 KEY_BITS=3, no valid message -> key_fail=1 after key 7 tried, secret_key=24'h000007, exactly 8 init_start pulses.
REQ-034 init_done held high from previous run at LAUNCH_INIT -> FSM stays in WAIT_INIT until a fresh rising edge.
REQ-035 reset asserted during WAIT_KSA at key 5 -> same-cycle all outputs 0; start afterwards begins at key 0.
REQ-036 start pulsed during WAIT_DEC -> no effect; start in FOUND -> new search from key 0, key_found cleared.
